// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Writer side of the instruction memory. Accepts a stream of W-bit machine-code
// words over a valid/ready handshake and writes them to consecutive instruction
// memory addresses starting at 0. The CPU is held while a program is written.
//
// Optional feature macro: INST_LOADER_CHECKSUM_EN
//   When defined, a trailer word follows the data. It is compared against the
//   mod-2**W sum of the data words. A mismatch sets a sticky error flag.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_start      pulse to begin a load of i_length words (sampled in IDLE only)
//   i_length     word count; values above 2**A saturate to 2**A
//   i_in_valid   source has a word on i_in_data
//   i_in_data    machine-code word from the source
//   o_in_ready   loader accepts i_in_data this cycle (decoded from state)
//   o_wr_en      instruction-memory write strobe
//   o_wr_addr    instruction-memory write address
//   o_wr_data    instruction-memory write data
//   o_busy       load in progress
//   o_done       one-cycle pulse at the end of a load
//   o_cpu_hold   hold the processor in reset while high
//   o_error      checksum mismatch, sticky until the next accepted start
// -----------------------------------------------------------------------------
module inst_loader #(
   parameter int unsigned A = 12,
   parameter int unsigned W = 9
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [A:0]   i_length,
   input  logic         i_in_valid,
   input  logic [W-1:0] i_in_data,
   output logic         o_in_ready,
   output logic         o_wr_en,
   output logic [A-1:0] o_wr_addr,
   output logic [W-1:0] o_wr_data,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_cpu_hold,
   output logic         o_error
);

   localparam int unsigned CNT_W = A + 1;
   localparam logic [CNT_W-1:0] DEPTH = {1'b1, {A{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state,     w_state;
   logic [CNT_W-1:0] r_remaining, w_remaining;
   logic [A-1:0]     r_addr,      w_addr;
   logic             r_wr_en,     w_wr_en;
   logic [A-1:0]     r_wr_addr,   w_wr_addr;
   logic [W-1:0]     r_wr_data,   w_wr_data;
   logic             r_busy;
   logic             r_done;
   logic             w_hs;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [W-1:0]     r_sum,       w_sum;
   logic             r_error,     w_error;
`endif

   // Ready is a pure decode of the state register
`ifdef INST_LOADER_CHECKSUM_EN
   assign o_in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
   assign o_in_ready = (r_state == S_LOAD);
`endif

   assign w_hs = i_in_valid & o_in_ready;

   // Next-state and datapath update
   always_comb begin
      w_state     = r_state;
      w_remaining = r_remaining;
      w_addr      = r_addr;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_wr_addr;
      w_wr_data   = r_wr_data;
`ifdef INST_LOADER_CHECKSUM_EN
      w_sum       = r_sum;
      w_error     = r_error;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
`ifdef INST_LOADER_CHECKSUM_EN
               w_sum   = '0;
               w_error = 1'b0;
`endif
               w_addr = '0;
               if (i_length == '0) begin
                  w_state = S_DONE;
               end else begin
                  w_remaining = (i_length > DEPTH) ? DEPTH : i_length;
                  w_state     = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (w_hs) begin
               w_wr_en     = 1'b1;
               w_wr_addr   = r_addr;
               w_wr_data   = i_in_data;
               w_remaining = r_remaining - CNT_W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
               w_sum       = r_sum + i_in_data;
`endif
               // Address is held on the last word so a full-depth load never wraps
               if (r_remaining == CNT_W'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  w_state = S_CHECK;
`else
                  w_state = S_DONE;
`endif
               end else begin
                  w_addr = r_addr + A'(1);
               end
            end
         end
`ifdef INST_LOADER_CHECKSUM_EN
         S_CHECK: begin
            // Trailer word is compared only, never written
            if (w_hs) begin
               if (i_in_data != r_sum) begin
                  w_error = 1'b1;
               end
               w_state = S_DONE;
            end
         end
`endif
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_addr      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
         r_sum       <= '0;
         r_error     <= 1'b0;
`endif
      end else begin
         r_state     <= w_state;
         r_remaining <= w_remaining;
         r_addr      <= w_addr;
         r_wr_en     <= w_wr_en;
         r_wr_addr   <= w_wr_addr;
         r_wr_data   <= w_wr_data;
         r_busy      <= (w_state != S_IDLE);
         r_done      <= (w_state == S_DONE);
`ifdef INST_LOADER_CHECKSUM_EN
         r_sum       <= w_sum;
         r_error     <= w_error;
`endif
      end
   end

   assign o_wr_en    = r_wr_en;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_busy     = r_busy;
   assign o_cpu_hold = r_busy;
   assign o_done     = r_done;
`ifdef INST_LOADER_CHECKSUM_EN
   assign o_error    = r_error;
`else
   assign o_error    = 1'b0;
`endif

endmodule
